// File: rtl/lb_reg_pkg.sv
// Shared constants for the oscope local-bus register bank: window layout,
// fixed offsets and the legal range of the read latency.
package lb_reg_pkg;

  localparam int WIN_WORDS  = 16;
  localparam int RD_LAT_MIN = 2;
  localparam int RD_LAT_MAX = 8;
  localparam int N_REG_MAX  = 8;
  localparam int N_STAT_MAX = 5;

  localparam logic [3:0] OFF_PULSE  = 4'd8;
  localparam logic [3:0] OFF_STICKY = 4'd9;
  localparam logic [3:0] OFF_STAT0  = 4'd10;
  localparam logic [3:0] OFF_ID     = 4'd15;

endpackage

// File: rtl/lb_reg_bank_if.sv
// Local-bus transaction signals between the base infrastructure (master)
// and an application register bank (slave).
interface lb_reg_bank_if #(
  parameter int AW = 24
) ();

  // A transaction is one cycle of lb_strobe qualified by lb_rd / lb_write;
  // there is no ready: the slave accepts every strobe, and read data comes
  // back later on lb_din, valid only in the single cycle lb_rd_valid is high.
  logic [AW-1:0] lb_addr;
  logic          lb_strobe;
  logic          lb_rd;
  logic          lb_write;
  logic [31:0]   lb_data_out;
  logic [31:0]   lb_din;
  logic          lb_rd_valid;

  modport master (
    output lb_addr, lb_strobe, lb_rd, lb_write, lb_data_out,
    input  lb_din, lb_rd_valid
  );

  modport slave (
    input  lb_addr, lb_strobe, lb_rd, lb_write, lb_data_out,
    output lb_din, lb_rd_valid
  );

endinterface

// File: rtl/lb_rd_pipe.sv
// Fixed-length delay line for {valid, data}; data only advances with valid,
// so the output data holds its last returned value between valid cycles.
module lb_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      wire unused_ok = &{1'b0, clk, rst_n};
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_pipe
      logic [DEPTH-1:0] v;
      logic [W-1:0]     d [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v <= '0;
          for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
          v[0] <= in_valid;
          if (in_valid) d[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            v[i] <= v[i-1];
            if (v[i-1]) d[i] <= d[i-1];
          end
        end
      end

      assign out_valid = v[DEPTH-1];
      assign out_data  = d[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lb_reg_bank.sv
// Oscope local-bus slave: config registers with write strobes, write-one
// pulse register, sticky event register, status words and a fixed-latency read path.
module lb_reg_bank
  import lb_reg_pkg::*;
#(
  parameter int                  AW       = 24,
  parameter int                  N_REG    = 8,
  parameter int                  N_STAT   = 4,
  parameter int                  RD_LAT   = 3,
  parameter logic [AW-1:0]       BASE     = '0,
  parameter logic [32*N_REG-1:0] REG_INIT = '0,
  parameter logic [31:0]         ID_WORD  = 32'h05C0_0001
) (
  input  logic                 lb_clk,
  input  logic                 rst_n,
  lb_reg_bank_if.slave         lb,
  output logic [32*N_REG-1:0]  reg_out,
  output logic [N_REG-1:0]     reg_wstb,
  output logic [31:0]          pulse_out,
  input  logic [31:0]          event_in,
  input  logic [32*N_STAT-1:0] status_in
);

  generate
    if (N_REG < 1 || N_REG > N_REG_MAX) begin : g_bad_n_reg
      $error("lb_reg_bank: N_REG must be 1..8");
    end
    if (N_STAT < 1 || N_STAT > N_STAT_MAX) begin : g_bad_n_stat
      $error("lb_reg_bank: N_STAT must be 1..5");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("lb_reg_bank: RD_LAT must be 2..8");
    end
    if ((BASE % WIN_WORDS) != 0) begin : g_bad_base
      $error("lb_reg_bank: BASE must be aligned to the 16-word window");
    end
  endgenerate

  logic        hit;
  logic [3:0]  off;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] regs [N_REG];
  logic [31:0] sticky;
  logic [31:0] sticky_clr;

  assign hit   = (lb.lb_addr[AW-1:4] == BASE[AW-1:4]);
  assign off   = lb.lb_addr[3:0];
  // A strobe with both qualifiers set is a read; it must not touch any write state.
  assign wr_en = lb.lb_strobe & lb.lb_write & ~lb.lb_rd & hit;
  assign rd_en = lb.lb_strobe & lb.lb_rd;

  assign sticky_clr = (wr_en && off == OFF_STICKY) ? lb.lb_data_out : '0;

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REG; i++) regs[i] <= REG_INIT[32*i +: 32];
      reg_wstb  <= '0;
      pulse_out <= '0;
      sticky    <= '0;
    end else begin
      for (int i = 0; i < N_REG; i++) begin
        reg_wstb[i] <= wr_en && (off == 4'(i));
        if (wr_en && (off == 4'(i))) regs[i] <= lb.lb_data_out;
      end
      pulse_out <= (wr_en && off == OFF_PULSE) ? lb.lb_data_out : '0;
      // Set is applied after clear so a simultaneous event is never lost.
      sticky    <= (sticky & ~sticky_clr) | event_in;
    end
  end

  for (genvar g = 0; g < N_REG; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs[g];
  end

  logic        rd_v1;
  logic [3:0]  rd_off1;
  logic        rd_hit1;
  logic        rd_v2;
  logic [31:0] rd_d2;
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (rd_hit1) begin
      for (int i = 0; i < N_REG; i++)
        if (rd_off1 == 4'(i)) rd_mux = regs[i];
      for (int j = 0; j < N_STAT; j++)
        if (rd_off1 == 4'(int'(OFF_STAT0) + j)) rd_mux = status_in[32*j +: 32];
      if (rd_off1 == OFF_STICKY) rd_mux = sticky;
      if (rd_off1 == OFF_ID)     rd_mux = ID_WORD;
    end
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1   <= 1'b0;
      rd_off1 <= '0;
      rd_hit1 <= 1'b0;
      rd_v2   <= 1'b0;
      rd_d2   <= '0;
    end else begin
      rd_v1   <= rd_en;
      rd_off1 <= off;
      rd_hit1 <= hit;
      rd_v2   <= rd_v1;
      if (rd_v1) rd_d2 <= rd_mux;
    end
  end

  lb_rd_pipe #(
    .DEPTH (RD_LAT - 2),
    .W     (32)
  ) u_rd_pipe (
    .clk       (lb_clk),
    .rst_n     (rst_n),
    .in_valid  (rd_v2),
    .in_data   (rd_d2),
    .out_valid (lb.lb_rd_valid),
    .out_data  (lb.lb_din)
  );

endmodule

// File: tb/tb_lb_reg_bank.sv
// Directed bench for lb_reg_bank: three instances (RD_LAT 3, 2, 8) share
// one stimulus stream so read timing is checked for each latency.
module tb_lb_reg_bank;

  localparam logic [23:0]  BASE = 24'h000100;
  localparam logic [255:0] REG_INIT_TB = {
    32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004,
    32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
  localparam logic [31:0] ID = 32'h05C0_0001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [23:0]  addr = '0;
  logic         strobe = 1'b0;
  logic         rd = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  wdata = '0;
  logic [31:0]  event_in = '0;
  logic [127:0] status_in = {32'h0, 32'h0, 32'h0, 32'h5A5A_0000};

  logic [255:0] reg_out3, reg_out2, reg_out8;
  logic [7:0]   reg_wstb3, reg_wstb2, reg_wstb8;
  logic [31:0]  pulse3, pulse2, pulse8;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lb_reg_bank_if #(.AW(24)) bus3 ();
  lb_reg_bank_if #(.AW(24)) bus2 ();
  lb_reg_bank_if #(.AW(24)) bus8 ();

  assign bus3.lb_addr = addr;  assign bus3.lb_strobe = strobe;  assign bus3.lb_rd = rd;
  assign bus3.lb_write = write;  assign bus3.lb_data_out = wdata;
  assign bus2.lb_addr = addr;  assign bus2.lb_strobe = strobe;  assign bus2.lb_rd = rd;
  assign bus2.lb_write = write;  assign bus2.lb_data_out = wdata;
  assign bus8.lb_addr = addr;  assign bus8.lb_strobe = strobe;  assign bus8.lb_rd = rd;
  assign bus8.lb_write = write;  assign bus8.lb_data_out = wdata;

  lb_reg_bank #(.AW(24), .N_REG(8), .N_STAT(4), .RD_LAT(3), .BASE(BASE),
                .REG_INIT(REG_INIT_TB), .ID_WORD(ID)) dut3 (
    .lb_clk(clk), .rst_n(rst_n), .lb(bus3), .reg_out(reg_out3), .reg_wstb(reg_wstb3),
    .pulse_out(pulse3), .event_in(event_in), .status_in(status_in));

  lb_reg_bank #(.AW(24), .N_REG(8), .N_STAT(4), .RD_LAT(2), .BASE(BASE),
                .REG_INIT(REG_INIT_TB), .ID_WORD(ID)) dut2 (
    .lb_clk(clk), .rst_n(rst_n), .lb(bus2), .reg_out(reg_out2), .reg_wstb(reg_wstb2),
    .pulse_out(pulse2), .event_in(event_in), .status_in(status_in));

  lb_reg_bank #(.AW(24), .N_REG(8), .N_STAT(4), .RD_LAT(8), .BASE(BASE),
                .REG_INIT(REG_INIT_TB), .ID_WORD(ID)) dut8 (
    .lb_clk(clk), .rst_n(rst_n), .lb(bus8), .reg_out(reg_out8), .reg_wstb(reg_wstb8),
    .pulse_out(pulse8), .event_in(event_in), .status_in(status_in));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [23:0] a, input logic [31:0] d);
    addr = a;  wdata = d;  strobe = 1'b1;  write = 1'b1;  rd = 1'b0;
    tick();
    strobe = 1'b0;  write = 1'b0;
  endtask

  // One read strobe, then watch all three instances for 12 cycles.
  task automatic do_read(input logic [23:0] a, input logic [31:0] exp,
                         input string tag, input logic both);
    int lat3, lat2, lat8, n3, n2, n8;
    logic [31:0] d3, d2, d8;
    lat3 = 0;  lat2 = 0;  lat8 = 0;  n3 = 0;  n2 = 0;  n8 = 0;
    d3 = 'x;  d2 = 'x;  d8 = 'x;
    addr = a;  strobe = 1'b1;  rd = 1'b1;  write = both;  wdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        strobe = 1'b0;  rd = 1'b0;  write = 1'b0;
        if (both) check({tag, "_no_wstb"}, 256'(reg_wstb3), 256'(8'h00));
      end
      if (bus3.lb_rd_valid) begin n3++; if (lat3 == 0) lat3 = c; d3 = bus3.lb_din; end
      if (bus2.lb_rd_valid) begin n2++; if (lat2 == 0) lat2 = c; d2 = bus2.lb_din; end
      if (bus8.lb_rd_valid) begin n8++; if (lat8 == 0) lat8 = c; d8 = bus8.lb_din; end
    end
    check({tag, "_lat3"}, 256'(lat3), 256'(3));
    check({tag, "_cnt3"}, 256'(n3), 256'(1));
    check({tag, "_data3"}, 256'(d3), 256'(exp));
    check({tag, "_lat2"}, 256'(lat2), 256'(2));
    check({tag, "_cnt2"}, 256'(n2), 256'(1));
    check({tag, "_data2"}, 256'(d2), 256'(exp));
    check({tag, "_lat8"}, 256'(lat8), 256'(8));
    check({tag, "_cnt8"}, 256'(n8), 256'(1));
    check({tag, "_data8"}, 256'(d8), 256'(exp));
  endtask

  task automatic check_reset_values(input string tag, input logic [255:0] exp_regs);
    check({tag, "_din"}, 256'(bus3.lb_din), 256'(0));
    check({tag, "_valid"}, 256'({bus3.lb_rd_valid, bus2.lb_rd_valid, bus8.lb_rd_valid}), 256'(0));
    check({tag, "_reg_out3"}, reg_out3, exp_regs);
    check({tag, "_reg_out2"}, reg_out2, exp_regs);
    check({tag, "_reg_out8"}, reg_out8, exp_regs);
    check({tag, "_wstb"}, 256'({reg_wstb3, reg_wstb2, reg_wstb8}), 256'(0));
    check({tag, "_pulse"}, 256'({pulse3, pulse2, pulse8}), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp_regs;
    int n_valid;

    // Reset
    rst_n = 1'b0;
    tick();  tick();
    check_reset_values("reset", REG_INIT_TB);
    rst_n = 1'b1;
    tick();

    // Config write and readback
    exp_regs = REG_INIT_TB;
    exp_regs[64 +: 32] = 32'h1234_5678;
    do_write(BASE + 24'd2, 32'h1234_5678);
    check("wr2_wstb", 256'(reg_wstb3), 256'(8'b0000_0100));
    check("wr2_reg_out", reg_out3, exp_regs);
    tick();
    check("wr2_wstb_drop", 256'(reg_wstb3), 256'(8'h00));
    do_read(BASE + 24'd2, 32'h1234_5678, "rd2", 1'b0);

    // Back-to-back reads: ID, empty status word, window miss
    addr = BASE + 24'd15;  strobe = 1'b1;  rd = 1'b1;
    tick();
    addr = BASE + 24'd13;
    tick();
    addr = BASE + 24'h20;
    tick();
    strobe = 1'b0;  rd = 1'b0;
    check("b2b_v0", 256'(bus3.lb_rd_valid), 256'(1));
    check("b2b_d0", 256'(bus3.lb_din), 256'(ID));
    tick();
    check("b2b_v1", 256'(bus3.lb_rd_valid), 256'(1));
    check("b2b_d1", 256'(bus3.lb_din), 256'(0));
    tick();
    check("b2b_v2", 256'(bus3.lb_rd_valid), 256'(1));
    check("b2b_d2", 256'(bus3.lb_din), 256'(0));
    tick();
    check("b2b_v3", 256'(bus3.lb_rd_valid), 256'(0));
    for (int i = 0; i < 8; i++) tick();

    // Status word 0
    do_read(BASE + 24'd10, 32'h5A5A_0000, "stat0", 1'b0);

    // Sticky set / clear / set-wins
    event_in = 32'h0000_0011;
    tick();
    event_in = '0;
    do_read(BASE + 24'd9, 32'h0000_0011, "sticky_set", 1'b0);
    event_in = 32'h0000_0001;
    do_write(BASE + 24'd9, 32'h0000_0001);
    event_in = '0;
    do_read(BASE + 24'd9, 32'h0000_0011, "sticky_setwins", 1'b0);
    do_write(BASE + 24'd9, 32'h0000_0001);
    do_read(BASE + 24'd9, 32'h0000_0010, "sticky_clr", 1'b0);

    // Pulse register
    do_write(BASE + 24'd8, 32'h8000_0003);
    check("pulse_hi", 256'(pulse3), 256'(32'h8000_0003));
    check("pulse_hi8", 256'(pulse8), 256'(32'h8000_0003));
    check("pulse_wstb", 256'(reg_wstb3), 256'(8'h00));
    tick();
    check("pulse_lo", 256'(pulse3), 256'(0));
    check("pulse_lo2", 256'(pulse2), 256'(0));
    check("pulse_regs", reg_out3, exp_regs);
    do_read(BASE + 24'd8, 32'h0, "pulse_rd", 1'b0);

    // Read and write together: read only
    do_read(BASE + 24'd1, 32'hA000_0001, "rdwr", 1'b1);
    check("rdwr_regs", reg_out3, exp_regs);
    do_read(BASE + 24'd1, 32'hA000_0001, "rdwr_after", 1'b0);

    // Reset while a read is in flight
    addr = BASE + 24'd2;  strobe = 1'b1;  rd = 1'b1;
    tick();
    strobe = 1'b0;  rd = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst", REG_INIT_TB);
    tick();
    check_reset_values("midrst_hold", REG_INIT_TB);
    tick();
    rst_n = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus3.lb_rd_valid || bus2.lb_rd_valid || bus8.lb_rd_valid) n_valid++;
    end
    check("midrst_no_valid", 256'(n_valid), 256'(0));
    do_read(BASE + 24'd2, 32'hA000_0002, "post_rst", 1'b0);
    do_read(BASE + 24'd9, 32'h0, "post_rst_sticky", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lb_reg_bank.md
Name: lb_reg_bank

Overview:
- Local-bus slave between the base-infrastructure local bus (lb_addr/lb_strobe/lb_rd/lb_write/lb_data_out) and the oscope application logic.
- Holds writable configuration registers, single-cycle write pulses, a sticky event register and read-only status words.
- Returns read data on lb_din with a fixed, parameterised latency, qualified by lb_rd_valid, for the base's readback path.
- Single clock domain (lb_clk).

Parameters:
- AW, 24, local-bus address width
- N_REG, 8, number of read/write config registers
- N_STAT, 4, number of read-only 32-bit status words
- RD_LAT, 3, cycles from read strobe to lb_rd_valid; legal range 2..8
- BASE, 24'h000000, window base; the window is 16 words aligned to 16
- REG_INIT, {N_REG{32'h0}}, flattened reset values of the config registers
- ID_WORD, 32'h05C0_0001, constant returned at offset 15

Ports:
- lb_clk  in  1  local-bus clock
- rst_n  in  1  asynchronous active-low reset
- lb_addr  in  AW  transaction address
- lb_strobe  in  1  transaction valid, one cycle per transaction
- lb_rd  in  1  read qualifier
- lb_write  in  1  write qualifier
- lb_data_out  in  32  write data from the host
- lb_din  out  32  read data to the host
- lb_rd_valid  out  1  read data valid
- reg_out  out  32*N_REG  config register contents, flattened
- reg_wstb  out  N_REG  one-cycle pulse on each accepted write
- pulse_out  out  32  write-one pulse bits
- event_in  in  32  sticky event set inputs
- status_in  in  32*N_STAT  read-only status words, flattened

Behaviour:
- Address hit: lb_addr[AW-1:4] == BASE[AW-1:4]. Offset is lb_addr[3:0].
- Address map:
  - 0..N_REG-1: config registers (read/write)
  - 8: pulse register (write-only; reads 0)
  - 9: sticky register (read; write-one-to-clear)
  - 10..10+N_STAT-1: status words
  - 15: ID_WORD
  - every other offset reads 0
- Write accepted when lb_strobe & lb_write & ~lb_rd & hit.
  - Config register updates on that edge.
  - reg_wstb[i] is high for exactly the following cycle.
- Pulse register: a write drives pulse_out = lb_data_out for exactly one cycle after the edge, then 0.
- Sticky register:
  - sticky |= event_in every cycle.
  - A write clears the bits set in lb_data_out.
  - If set and clear hit the same bit in the same cycle, set wins.
- lb_rd & lb_write both high on a strobe: treated as a read only; no write side effects.
- Read accepted when lb_strobe & lb_rd, hit or not. Misses return 0 but still produce lb_rd_valid, so the host never stalls.
- Read pipeline:
  - Cycle 0: the strobe cycle.
  - Cycle 1: offset and hit registered.
  - Cycle 2: data muxed and registered. Register contents are sampled here, so a write accepted in cycle 0 or 1 of an earlier transaction is visible.
  - Further delay registers pad the path so lb_din and lb_rd_valid go high together exactly RD_LAT cycles after the strobe, for one cycle each.
- Back-to-back reads on consecutive cycles are fully supported: each yields its own valid cycle, in order.
- lb_din holds its last value when lb_rd_valid is 0.
- status_in and event_in are already in the lb_clk domain; no synchronisers inside this block.
- Reset values:
  - reg_out = REG_INIT
  - reg_wstb = 0, pulse_out = 0, sticky = 0
  - lb_din = 0, lb_rd_valid = 0
  - read pipeline cleared
- Reset asserted mid-read: in-flight reads are discarded and no lb_rd_valid is emitted for them after release.
- Elaboration error if N_REG > 8, N_STAT > 5, or RD_LAT is outside 2..8.

Decomposition:
- Package lb_reg_pkg holds:
  - offset constants: OFF_PULSE = 8, OFF_STICKY = 9, OFF_STAT0 = 10, OFF_ID = 15
  - window size (16)
  - the RD_LAT bounds
- Sub-module lb_rd_pipe: a parameterised delay line of {valid, data} with length RD_LAT-2 (a pass-through when 0), with async clear.
- Decode and register file stay in lb_reg_bank.

Test Plan:
- Write 32'h1234_5678 to BASE+2, then read it back → lb_rd_valid exactly 3 cycles after the read strobe, lb_din = 32'h1234_5678. reg_wstb = 8'b0000_0100 for one cycle; other reg_out words unchanged.
- Reads of BASE+15, BASE+13 and BASE+0x20 (miss) on three consecutive strobes → three consecutive valid cycles returning 32'h05C0_0001, 0, 0.
- event_in = 32'h0000_0011 for one cycle → sticky read returns 32'h11. Write 32'h01 to BASE+9 while event_in[0] = 1 in the same cycle → sticky stays 32'h11. Repeat the write with event_in = 0 → 32'h10.
- Write 32'h8000_0003 to BASE+8 → pulse_out = 32'h8000_0003 for exactly one cycle, then 0. Read of BASE+8 returns 0.
- Strobe with lb_rd = lb_write = 1 to BASE+1 with data 32'hFFFF_FFFF → no reg_wstb; a read returns REG_INIT word 1. Run again with RD_LAT = 2 and 8 and check valid timing for each.
- Issue a read strobe, then assert rst_n = 0 one cycle later for 2 cycles → no lb_rd_valid pulse ever appears for it; all outputs are at reset values during reset; a read after release returns REG_INIT.
